// File: rtl/dma_pkg.sv
// Shared definitions for the packet-to-memory receive DMA: frame magic,
// byte-lane geometry, FSM state encoding and the RMW merge-mask helper.
package dma_pkg;

    localparam logic [7:0]  DMA_MAGIC = 8'h44;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned LANES     = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_WRITE,
        ST_RMW_READ,
        ST_RMW_WAIT,
        ST_DRAIN,
        ST_DONE
    } dma_state_t;

    // Lanes at or above the filled count take their value from memory.
    function automatic logic [LANES-1:0] merge_mask(input logic [1:0] filled);
        logic [LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            mask[i] = (i >= 32'(filled));
        end
        return mask;
    endfunction

endpackage

// File: rtl/dma_word_packer.sv
// Assembles payload bytes into a little-endian word and merges memory data
// into the unfilled lanes for a read-modify-write of a partial word.
module dma_word_packer
    import dma_pkg::*;
(
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      clear,
    input  logic                      insert,
    input  logic [LANE_W-1:0]         data,
    input  logic                      merge,
    input  logic [LANES*LANE_W-1:0]   read_data,
    output logic [LANES*LANE_W-1:0]   word,
    output logic [1:0]                step
);

    logic [LANES-1:0] mask;

    always_comb begin
        mask = merge_mask(step);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            word <= '0;
            step <= '0;
        end else if (clear) begin
            word <= '0;
            step <= '0;
        end else if (insert) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i == 32'(step)) begin
                    word[i*LANE_W +: LANE_W] <= data;
                end
            end
            step <= step + 2'd1;
        end else if (merge) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (mask[i]) begin
                    word[i*LANE_W +: LANE_W] <= read_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/dma_packet_to_memory.sv
// Receive DMA: parses magic + big-endian length framing and writes the payload
// to memory as little-endian words, using read-modify-write for a partial tail.
module dma_packet_to_memory
  import dma_pkg::*;
#(
  parameter logic [7:0]  MAGIC         = DMA_MAGIC,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     enable_valid,
  input  logic [ADDRESS_WIDTH-1:0] enable_value_address,
  input  logic                     input_packet_valid,
  input  logic [7:0]               input_packet_data,
  input  logic                     input_packet_last,
  output logic                     input_packet_ready,
  output logic                     memory_memory_valid,
  output logic [ADDRESS_WIDTH-1:0] memory_memory_address,
  output logic                     memory_memory_write,
  output logic [DATA_WIDTH-1:0]    memory_memory_write_data,
  input  logic                     memory_ready,
  input  logic                     memory_response_valid,
  input  logic [DATA_WIDTH-1:0]    memory_response_read_data,
  input  logic                     memory_response_error,
  output logic                     mem_response_memory_response_ready,
  output logic                     busy,
  output logic                     done_,
  output logic                     error
);

  dma_state_t               state;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [15:0]              length;
  logic [15:0]              length_dec;
  logic                     err_flag;
  logic                     last_seen;
  logic                     accept;
  logic                     pack_clear;
  logic                     pack_insert;
  logic                     pack_merge;
  logic [DATA_WIDTH-1:0]    word;
  logic [1:0]               step;

  assign input_packet_ready = state inside {ST_MAGIC, ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD, ST_DRAIN};
  assign memory_memory_valid      = (state == ST_WRITE) || (state == ST_RMW_READ);
  assign memory_memory_write      = (state == ST_WRITE);
  assign memory_memory_address    = address;
  assign memory_memory_write_data = word;
  assign mem_response_memory_response_ready = 1'b1;
  assign busy  = (state != ST_IDLE);
  assign done_ = (state == ST_DONE);
  assign error = (state == ST_DONE) && err_flag;

  assign accept      = input_packet_valid && input_packet_ready;
  assign length_dec  = length - 16'd1;
  assign pack_insert = (state == ST_PAYLOAD) && accept;
  assign pack_merge  = (state == ST_RMW_WAIT) && memory_response_valid && !memory_response_error;
  assign pack_clear  = ((state == ST_WRITE) && memory_ready) || ((state == ST_IDLE) && enable_valid);

  dma_word_packer u_packer (
    .clock     (clock),
    .clear_n   (clear_n),
    .clear     (pack_clear),
    .insert    (pack_insert),
    .data      (input_packet_data),
    .merge     (pack_merge),
    .read_data (memory_response_read_data),
    .word      (word),
    .step      (step)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= ST_IDLE;
      address   <= '0;
      length    <= '0;
      err_flag  <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_valid) begin
            address   <= enable_value_address & ~ADDRESS_WIDTH'(3);
            length    <= '0;
            err_flag  <= 1'b0;
            last_seen <= 1'b0;
            state     <= ST_MAGIC;
          end
        end
        ST_MAGIC: begin
          if (accept) begin
            if (input_packet_data != MAGIC) begin
              err_flag <= 1'b1;
              state    <= input_packet_last ? ST_DONE : ST_DRAIN;
            end else if (input_packet_last) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_LEN_HI;
            end
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            length[15:8] <= input_packet_data;
            if (input_packet_last) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_LEN_LO;
            end
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            length[7:0] <= input_packet_data;
            if ({length[15:8], input_packet_data} == 16'd0) begin
              state <= ST_DONE;
            end else if (input_packet_last) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            length    <= length_dec;
            last_seen <= input_packet_last;
            if (input_packet_last && (length > 16'd1)) begin
              err_flag <= 1'b1;
            end
            // A full word always goes straight out; a partial one needs RMW.
            if (step == 2'd3) begin
              state <= ST_WRITE;
            end else if ((length_dec == 16'd0) || input_packet_last) begin
              state <= ST_RMW_READ;
            end
          end
        end
        ST_WRITE: begin
          if (memory_ready) begin
            address <= address + ADDRESS_WIDTH'(4);
            if (last_seen) begin
              state <= ST_DONE;
            end else if (length == 16'd0) begin
              state <= ST_DRAIN;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_RMW_READ: begin
          if (memory_ready) begin
            state <= ST_RMW_WAIT;
          end
        end
        ST_RMW_WAIT: begin
          if (memory_response_valid) begin
            if (memory_response_error) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && input_packet_last) begin
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_packet_to_memory.sv
// Directed bench for dma_packet_to_memory: framed byte streams against a
// simple memory responder, with hand-computed expected writes and status.
module tb_dma_packet_to_memory;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        enable_valid = 1'b0;
  logic [31:0] enable_address = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_valid;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_error = 1'b0;
  logic        resp_ready;
  logic        busy;
  logic        done_;
  logic        error;

  logic [31:0] rd_value = '0;
  logic        rd_err = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  dma_packet_to_memory dut (
    .clock                              (clock),
    .clear_n                            (clear_n),
    .enable_valid                       (enable_valid),
    .enable_value_address               (enable_address),
    .input_packet_valid                 (in_valid),
    .input_packet_data                  (in_data),
    .input_packet_last                  (in_last),
    .input_packet_ready                 (in_ready),
    .memory_memory_valid                (mem_valid),
    .memory_memory_address              (mem_address),
    .memory_memory_write                (mem_write),
    .memory_memory_write_data           (mem_wdata),
    .memory_ready                       (mem_ready),
    .memory_response_valid              (resp_valid),
    .memory_response_read_data          (resp_data),
    .memory_response_error              (resp_error),
    .mem_response_memory_response_ready (resp_ready),
    .busy                               (busy),
    .done_                              (done_),
    .error                              (error)
  );

  initial begin
    forever begin
      @(negedge clock);
      if (clear_n && mem_valid && mem_ready) begin
        if (mem_write) begin
          wr_addr_q.push_back(mem_address);
          wr_data_q.push_back(mem_wdata);
        end else begin
          rd_addr_q.push_back(mem_address);
          pend = 1'b1;
        end
      end
      @(posedge clock);
      #1;
      resp_valid = pend;
      resp_data  = pend ? rd_value : 32'h0;
      resp_error = pend ? rd_err : 1'b0;
      pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [31:0] a);
    @(posedge clock);
    #1;
    enable_valid   = 1'b1;
    enable_address = a;
    @(posedge clock);
    #1;
    enable_valid = 1'b0;
    check("busy_after_arm", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("byte_accept", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int n;
    n = 0;
    while (done_ !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(done_), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    @(posedge clock);
    #1;
    check({tag, "_pulse_end"}, {30'd0, done_, busy}, 32'd0);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_wr_present"}, 32'(wr_addr_q.size() > 0), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check({tag, "_wr_addr"}, wr_addr_q.pop_front(), a);
      check({tag, "_wr_data"}, wr_data_q.pop_front(), d);
    end
  endtask

  task automatic expect_idle_traffic(input string tag, input int reads);
    check({tag, "_no_extra_wr"}, 32'(wr_addr_q.size()), 32'd0);
    check({tag, "_reads"}, 32'(rd_addr_q.size()), 32'(reads));
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  initial begin
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done_), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_resp_ready", 32'(resp_ready), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear_n = 1'b1;

    arm(32'h0000_1000);
    send(8'h44, 0); send(8'h00, 0); send(8'h08, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
    wait_done("full", 1'b0);
    expect_write("full0", 32'h0000_1000, 32'h0403_0201);
    expect_write("full1", 32'h0000_1004, 32'h0807_0605);
    expect_idle_traffic("full", 0);

    rd_value = 32'h1122_3344; rd_err = 1'b0;
    arm(32'h0000_2003);
    send(8'h44, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'hAA, 0); send(8'hBB, 1);
    wait_done("rmw", 1'b0);
    check("rmw_rd_addr", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hDEAD_BEEF, 32'h0000_2000);
    expect_write("rmw", 32'h0000_2000, 32'h1122_BBAA);
    expect_idle_traffic("rmw", 1);

    arm(32'h0000_3000);
    send(8'h45, 0); send(8'h11, 0); send(8'h22, 1);
    wait_done("magic", 1'b1);
    expect_idle_traffic("magic", 0);

    arm(32'h0000_3000);
    send(8'h44, 0); send(8'h00, 0); send(8'h06, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    wait_done("trunc", 1'b1);
    expect_write("trunc", 32'h0000_3000, 32'h0403_0201);
    expect_idle_traffic("trunc", 0);

    arm(32'h0000_3800);
    send(8'h44, 0); send(8'h00, 0); send(8'h00, 1);
    check("zero_done_next", 32'(done_), 32'd1);
    wait_done("zero", 1'b0);
    expect_idle_traffic("zero", 0);

    rd_value = 32'h5555_5555; rd_err = 1'b1;
    arm(32'h0000_4000);
    send(8'h44, 0); send(8'h00, 0); send(8'h01, 0); send(8'h77, 1);
    wait_done("rderr", 1'b1);
    check("rderr_rd_addr", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hDEAD_BEEF, 32'h0000_4000);
    expect_idle_traffic("rderr", 1);
    rd_err = 1'b0;

    rd_value = 32'hFFFF_FFFF;
    arm(32'h0000_7000);
    send(8'h44, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'hC1, 0); send(8'hC2, 0); send(8'hD0, 0); send(8'hD1, 1);
    wait_done("drain", 1'b1);
    expect_write("drain", 32'h0000_7000, 32'hFFFF_C2C1);
    expect_idle_traffic("drain", 1);

    arm(32'hFFFF_FFFE);
    send(8'h44, 0); send(8'h00, 0); send(8'h08, 0);
    send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
    send(8'h15, 0); send(8'h16, 0); send(8'h17, 0); send(8'h18, 1);
    wait_done("wrap", 1'b0);
    expect_write("wrap0", 32'hFFFF_FFFC, 32'h1413_1211);
    expect_write("wrap1", 32'h0000_0000, 32'h1817_1615);
    expect_idle_traffic("wrap", 0);

    mem_ready = 1'b0;
    arm(32'h0000_5000);
    send(8'h44, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    repeat (3) @(negedge clock);
    check("stall_valid", {30'd0, mem_valid, mem_write}, 32'd3);
    check("stall_addr", mem_address, 32'h0000_5000);
    check("stall_data", mem_wdata, 32'h0403_0201);
    #2;
    clear_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_valid", 32'(mem_valid), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    clear_n   = 1'b1;
    mem_ready = 1'b1;
    expect_idle_traffic("abort", 0);

    arm(32'h0000_6000);
    send(8'h44, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
    wait_done("after", 1'b0);
    expect_write("after", 32'h0000_6000, 32'hA4A3_A2A1);
    expect_idle_traffic("after", 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
